// File: rtl/bcd_to_bin_pkg.sv
// rtl/bcd_to_bin_pkg.sv - shared constants, FSM states and digit check helper for bcd_to_bin
package bcd_pkg;

    localparam int DIGITS = 5;
    localparam int BIN_W  = 17;
    localparam int SHIFTS = 17;
    localparam int BCD_W  = 4 * DIGITS;
    localparam int SR_W   = BCD_W + BIN_W;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        FIN   = 2'd2
    } state_t;

    function automatic logic bcd_has_invalid(input logic [BCD_W-1:0] v);
        logic bad;
        bad = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (v[4*i +: 4] > 4'd9) begin
                bad = 1'b1;
            end
        end
        return bad;
    endfunction

endpackage

// File: rtl/bcd_to_bin_if.sv
// rtl/bcd_to_bin_if.sv - start/done request interface between a requester and bcd_to_bin
interface bcd_to_bin_if
    import bcd_pkg::*;
();
    logic             start;
    logic [BCD_W-1:0] bcd;
    logic             busy;
    logic             done;
    logic [BIN_W-1:0] bin;
    logic             err;

    modport master (
        output start,
        output bcd,
        input  busy,
        input  done,
        input  bin,
        input  err
    );

    modport slave (
        input  start,
        input  bcd,
        output busy,
        output done,
        output bin,
        output err
    );
endinterface

// File: rtl/bcd_to_bin_digit_adj.sv
// rtl/bcd_to_bin_digit_adj.sv - per-digit subtract-3 correction for reverse double-dabble
module bcd_digit_adj (
    input  logic [3:0] din,
    output logic [3:0] dout
);
    assign dout = (din >= 4'd8) ? (din - 4'd3) : din;
endmodule

// File: rtl/bcd_to_bin.sv
// rtl/bcd_to_bin.sv - sequential 5-digit BCD to 17-bit binary converter (optional BCD_CHECK_EN)
module bcd_to_bin
    import bcd_pkg::*;
(
    input  logic         clk,
    input  logic         clr_n,
    bcd_to_bin_if.slave  io
);
    state_t            state;
    logic [SR_W-1:0]   sr;
    logic [SR_W-1:0]   sr_shift;
    logic [SR_W-1:0]   sr_next;
    logic [4:0]        cnt;
    logic              busy_q;
    logic              done_q;
    logic [BIN_W-1:0]  bin_q;

    // Shift right, then correct each BCD digit that landed at >= 8.
    assign sr_shift = sr >> 1;
    assign sr_next[BIN_W-1:0] = sr_shift[BIN_W-1:0];

    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        bcd_digit_adj u_adj (
            .din  (sr_shift[BIN_W + 4*g +: 4]),
            .dout (sr_next[BIN_W + 4*g +: 4])
        );
    end

`ifdef BCD_CHECK_EN
    logic invalid;
    logic err_q;
`endif

    always_ff @(posedge clk) begin
        if (!clr_n) begin
            state  <= IDLE;
            sr     <= '0;
            cnt    <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            bin_q  <= '0;
`ifdef BCD_CHECK_EN
            invalid <= 1'b0;
            err_q   <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (io.start) begin
                        sr     <= {io.bcd, {BIN_W{1'b0}}};
                        cnt    <= '0;
                        busy_q <= 1'b1;
                        state  <= SHIFT;
`ifdef BCD_CHECK_EN
                        invalid <= bcd_has_invalid(io.bcd);
`endif
                    end
                end
                SHIFT: begin
                    sr  <= sr_next;
                    cnt <= cnt + 5'd1;
                    if (cnt == 5'(SHIFTS - 1)) begin
                        state <= FIN;
                    end
                end
                FIN: begin
`ifdef BCD_CHECK_EN
                    bin_q <= invalid ? '0 : sr[BIN_W-1:0];
                    err_q <= invalid;
`else
                    bin_q <= sr[BIN_W-1:0];
`endif
                    done_q <= 1'b1;
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign io.busy = busy_q;
    assign io.done = done_q;
    assign io.bin  = bin_q;
`ifdef BCD_CHECK_EN
    assign io.err  = err_q;
`else
    assign io.err  = 1'b0;
`endif

endmodule

// File: doc/bcd_to_bin.md
Name: bcd_to_bin

Overview:
Sequential BCD-to-binary converter using reverse double-dabble (shift-right / subtract-3). It takes five packed BCD digits (0..99999) and produces a 17-bit binary value. It is the inverse of the display-path binary-to-BCD converter and is used on the keypad/switch input path, where decimal digits entered by the user become operands for the CPU. One conversion runs at a time: start pulse in, done pulse out.

Parameters:
- DIGITS, 5, number of BCD digits; fixed at 5 for this block.
- BIN_W, 17, output width; ceil(log2(10^DIGITS)).
- Shift count equals BIN_W: 17 shift iterations per conversion.

Ports:
- clk  input  1  system clock; all logic on posedge.
- clr_n  input  1  synchronous active-low reset; sampled on posedge clk.
- start  input  1  request pulse; accepted only when busy=0.
- bcd  input  20  packed digits {d4,d3,d2,d1,d0}; d4 = ten-thousands in [19:16]. Sampled only on an accepted start.
- busy  output  1  high while a conversion is in progress.
- done  output  1  one-cycle pulse; bin is valid from this cycle onward.
- bin  output  17  binary result; holds until the next done.
- err  output  1  invalid-digit flag; see Optional Feature.

Behaviour:
- Reset (clr_n=0 at posedge) from any state, including mid-conversion:
  - state=IDLE, busy=0, done=0, bin=0, err=0, internal shift register=0, counter=0.
  - An in-flight conversion is abandoned and produces no done.
- Internal state:
  - 37-bit shift register sr={bcd_part[19:0], bin_part[16:0]}.
  - 5-bit iteration counter cnt.
- FSM states: IDLE, SHIFT, FIN.
- IDLE:
  - busy=0.
  - start=1 at edge k: sr<={bcd,17'b0}, cnt<=0, go to SHIFT.
  - start=0: remain in IDLE.
- SHIFT:
  - busy=1.
  - Each edge: sr<=sr>>1 (zero fill at MSB).
  - Then, in the same cycle, each 4-bit digit of the shifted sr[36:17] that is >=8 has 3 subtracted; the subtraction is 4-bit and cannot wrap because the digit is >=8.
  - cnt increments each edge.
  - After the 17th shift (cnt==16 at that edge), go to FIN.
- FIN:
  - busy=1.
  - One edge: bin<=sr[16:0], done<=1, go to IDLE.
- Latency and throughput:
  - start accepted at edge k; shifts occur at edges k+1..k+17.
  - bin updates and done rises at edge k+18, so done is high for the single cycle after edge k+18.
  - Minimum start-to-start spacing is 19 cycles.
- Handshake rules:
  - done is high for exactly 1 cycle. It coincides with the IDLE cycle, so busy=0 while done=1.
  - A start asserted in the same cycle as done is accepted.
  - start while busy=1 is ignored, not queued.
  - bcd changes during a conversion have no effect.
- Boundaries:
  - 00000 produces 0.
  - 99999 produces 0x1869F.
  - For valid input, the residual sr[36:17] after 17 shifts is always 0.

Optional Feature:
Macro BCD_CHECK_EN.
- Defined:
  - On an accepted start, any digit >9 sets an internal invalid bit.
  - At FIN: err<=invalid, and bin<=0 if invalid, else the normal result.
  - done still pulses; latency is unchanged.
  - err holds until the next done or reset.
- Not defined:
  - err is tied to 0.
  - Invalid digits are converted without checking. The output is deterministic but meaningless.

Decomposition:
- Package bcd_pkg holds:
  - Constants DIGITS=5, BIN_W=17, SHIFTS=17.
  - State typedef/localparams IDLE=2'd0, SHIFT=2'd1, FIN=2'd2.
- One sub-module, bcd_digit_adj: combinational 4-bit, out = (in>=8) ? in-3 : in. It is instantiated DIGITS times on the shifted upper field.
- The FSM, counter and register stay in bcd_to_bin.

Test Plan:
- Reset, then start with bcd=0x99999 -> busy for 18 cycles; done pulses once at start+18; bin=0x1869F (99999); err=0.
- bcd=0x12345 -> bin=0x03039. bcd=0x65536 -> bin=0x10000. bcd=0x00000 -> bin=0. Each case checks done-cycle timing and that bin holds afterwards.
- start held high continuously with bcd=0x00042 -> first done at +18 with bin=42. Next accept occurs in the done cycle; exactly one done per 19 cycles; no extra accepts while busy.
- Start with 0x00007, then change bcd to 0x99999 and pulse start at +5 -> result is 7; the second start is ignored.
- Pulse clr_n low at start+9 -> no done follows; busy=0, bin=0 next cycle. A new start with 0x00100 then completes normally with bin=100.
- With BCD_CHECK_EN defined, bcd=0xA0001 -> done at +18 with err=1, bin=0. A following 0x00001 gives err=0, bin=1. Without the macro, err stays 0 throughout.
